// File: rtl/bnn_serial_frontend.sv
// Serial front end for a combinational BNN classifier. It loads features one per beat,
// holds the packed word while the classifier settles, then returns the captured prediction.
module bnn_serial_frontend #(
  parameter int FEAT_CNT      = 12,
  parameter int FEAT_BITS     = 4,
  parameter int CLASS_CNT     = 6,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16,
  localparam int PRED_W       = $clog2(CLASS_CNT),
  localparam int W            = FEAT_CNT * FEAT_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FEAT_BITS-1:0] in_feat,
  output logic [W-1:0]      features,
  input  logic [PRED_W-1:0] prediction,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PRED_W-1:0] out_pred,
  output logic              class_err,
  output logic [CNT_W-1:0]  sample_cnt
);

  localparam int FI_W = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {LOAD, SETTLE, HOLD} state_t;

  state_t          state;
  logic [FI_W-1:0] feat_idx;
  logic [SC_W-1:0] settle_cnt;

  // Ready is a direct decode of the state register, so it never depends on in_valid.
  assign in_ready = (state == LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD;
      features   <= '0;
      feat_idx   <= '0;
      settle_cnt <= '0;
      out_valid  <= 1'b0;
      out_pred   <= '0;
      class_err  <= 1'b0;
      sample_cnt <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            features <= {features[W-FEAT_BITS-1:0], in_feat};
            if (feat_idx == FI_W'(FEAT_CNT - 1)) begin
              feat_idx   <= '0;
              settle_cnt <= '0;
              state      <= SETTLE;
            end else begin
              feat_idx <= feat_idx + 1'b1;
            end
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_cnt == SC_W'(SETTLE_CYCLES - 1)) begin
            out_pred  <= prediction;
            out_valid <= 1'b1;
            class_err <= class_err | (int'(prediction) >= CLASS_CNT);
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            sample_cnt <= sample_cnt + 1'b1;
            state      <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
